// File: rtl/parity_pkg.sv
// parity_pkg: shared FSM state encoding and parity-mode constants for parity_stream
package parity_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_HOLD
   } state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_tree.sv
// parity_tree: combinational XOR reduction of a WIDTH-bit word
module parity_tree #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] data_i,
   output logic             parity_o
);

   assign parity_o = ^data_i;

endmodule

// File: rtl/parity_stream.sv
// parity_stream: accumulates even/odd parity over valid/ready framed words and emits one registered result per frame
module parity_stream #(
   parameter int WIDTH     = 8,
   parameter int MAX_WORDS = 16,
   parameter int COUNT_W   = $clog2(MAX_WORDS + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_odd,
   input  logic               i_check,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [WIDTH-1:0]   s_data,
   input  logic               s_last,
   input  logic               s_par,
   output logic               m_valid,
   input  logic               m_ready,
   output logic               m_parity,
   output logic               m_error,
   output logic               m_overflow,
   output logic [COUNT_W-1:0] m_count
);

   import parity_pkg::*;

   state_e             state_q, state_d;
   logic               acc_q, acc_d;
   logic [COUNT_W-1:0] cnt_q, cnt_d;
   logic               odd_q, odd_d;
   logic               chk_q, chk_d;
   logic               valid_q, valid_d;
   logic               par_q, par_d;
   logic               err_q, err_d;
   logic               ovf_q, ovf_d;
   logic [COUNT_W-1:0] mcnt_q, mcnt_d;

   logic               word_par;
   logic               accept;
   logic               first;
   logic               acc_new;
   logic [COUNT_W-1:0] cnt_new;
   logic               odd_eff;
   logic               chk_eff;
   logic               close;
   logic               par_new;

   parity_tree #(.WIDTH(WIDTH)) u_tree (
      .data_i   (s_data),
      .parity_o (word_par)
   );

   // Only a pending result can stall the input, and then only until the consumer takes it
   assign s_ready = (state_q == ST_HOLD) ? m_ready : 1'b1;
   assign accept  = s_valid && s_ready;
   // Any word accepted outside ACCUM opens a new frame, including the restart from HOLD
   assign first   = (state_q != ST_ACCUM);
   assign acc_new = first ? word_par : (acc_q ^ word_par);
   assign cnt_new = first ? COUNT_W'(1) : (cnt_q + COUNT_W'(1));
   assign odd_eff = first ? i_odd : odd_q;
   assign chk_eff = first ? i_check : chk_q;
   assign close   = accept && (s_last || (cnt_new == COUNT_W'(MAX_WORDS)));
   assign par_new = acc_new ^ odd_eff;

   // Next-state, accumulator and result selection
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      odd_d   = odd_q;
      chk_d   = chk_q;
      valid_d = valid_q;
      par_d   = par_q;
      err_d   = err_q;
      ovf_d   = ovf_q;
      mcnt_d  = mcnt_q;
      if (accept) begin
         acc_d   = acc_new;
         cnt_d   = cnt_new;
         odd_d   = odd_eff;
         chk_d   = chk_eff;
         state_d = close ? ST_HOLD : ST_ACCUM;
      end
      if (close) begin
         valid_d = 1'b1;
         par_d   = par_new;
         err_d   = chk_eff && (par_new != s_par);
         ovf_d   = !s_last;
         mcnt_d  = cnt_new;
      end else if (state_q == ST_HOLD && m_ready) begin
         valid_d = 1'b0;
         state_d = accept ? ST_ACCUM : ST_IDLE;
      end
   end

   // State and output registers; reset drops any partial frame and pending result at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         acc_q   <= 1'b0;
         cnt_q   <= '0;
         odd_q   <= PAR_EVEN;
         chk_q   <= 1'b0;
         valid_q <= 1'b0;
         par_q   <= 1'b0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
         mcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         odd_q   <= odd_d;
         chk_q   <= chk_d;
         valid_q <= valid_d;
         par_q   <= par_d;
         err_q   <= err_d;
         ovf_q   <= ovf_d;
         mcnt_q  <= mcnt_d;
      end
   end

   assign m_valid    = valid_q;
   assign m_parity   = par_q;
   assign m_error    = err_q;
   assign m_overflow = ovf_q;
   assign m_count    = mcnt_q;

endmodule

// File: tb/tb_parity_stream.sv
// tb_parity_stream: directed self-checking bench for parity_stream (WIDTH=8, MAX_WORDS=4)
module tb_parity_stream;

   localparam int WIDTH     = 8;
   localparam int MAX_WORDS = 4;
   localparam int COUNT_W   = $clog2(MAX_WORDS + 1);

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               i_odd = 1'b0;
   logic               i_check = 1'b0;
   logic               s_valid = 1'b0;
   logic               s_ready;
   logic [WIDTH-1:0]   s_data = '0;
   logic               s_last = 1'b0;
   logic               s_par = 1'b0;
   logic               m_valid;
   logic               m_ready = 1'b1;
   logic               m_parity;
   logic               m_error;
   logic               m_overflow;
   logic [COUNT_W-1:0] m_count;

   int n_cmp = 0;
   int n_err = 0;

   parity_stream #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_odd      (i_odd),
      .i_check    (i_check),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_last     (s_last),
      .s_par      (s_par),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_parity   (m_parity),
      .m_error    (m_error),
      .m_overflow (m_overflow),
      .m_count    (m_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic last, input logic par, input logic odd, input logic chk);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      s_par   = par;
      i_odd   = odd;
      i_check = chk;
      tick();
      s_valid = 1'b0;
   endtask

   task automatic result(input string tag, input logic v, input logic p, input logic e, input logic o, input int c);
      check({tag, ".valid"}, 32'(m_valid), 32'(v));
      check({tag, ".parity"}, 32'(m_parity), 32'(p));
      check({tag, ".error"}, 32'(m_error), 32'(e));
      check({tag, ".ovf"}, 32'(m_overflow), 32'(o));
      check({tag, ".count"}, 32'(m_count), 32'(c));
   endtask

   initial begin
      #12;
      result("reset", 0, 0, 0, 0, 0);
      check("reset.s_ready", 32'(s_ready), 32'd1);
      rst_n = 1'b1;
      tick();
      // even generate, single word: A5 has four ones
      send(8'hA5, 1, 0, 0, 0);
      result("even_a5", 1, 0, 0, 0, 1);
      tick();
      check("even_a5.drop", 32'(m_valid), 32'd0);
      // odd generate, i_odd dropped after first word must not matter
      send(8'h01, 0, 0, 1, 0);
      check("odd.mid1", 32'(m_valid), 32'd0);
      send(8'h03, 0, 0, 0, 0);
      send(8'h07, 1, 0, 0, 0);
      result("odd_3w", 1, 1, 0, 0, 3);
      tick();
      // even check, FF has even weight so parity 0 mismatches s_par=1
      send(8'hFF, 1, 1, 0, 1);
      result("chk_err", 1, 0, 1, 0, 1);
      // back-to-back from HOLD: new frame closes on the same cycle
      send(8'hFF, 1, 0, 0, 1);
      result("chk_ok", 1, 0, 0, 0, 1);
      // backpressure: result held, input blocked
      m_ready = 1'b0;
      s_valid = 1'b1;
      s_data  = 8'h80;
      s_last  = 1'b1;
      s_par   = 1'b0;
      i_odd   = 1'b0;
      i_check = 1'b0;
      #1;
      check("bp.s_ready", 32'(s_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp.s_ready_hold", 32'(s_ready), 32'd0);
         result("bp.hold", 1, 0, 0, 0, 1);
      end
      m_ready = 1'b1;
      #1;
      check("bp.s_ready_rel", 32'(s_ready), 32'd1);
      tick();
      s_valid = 1'b0;
      result("bp_80", 1, 1, 0, 0, 1);
      tick();
      check("bp_80.drop", 32'(m_valid), 32'd0);
      // overflow: MAX_WORDS words without s_last
      send(8'h01, 0, 0, 0, 0);
      send(8'h01, 0, 0, 0, 0);
      send(8'h01, 0, 0, 0, 0);
      check("ovf.mid3", 32'(m_valid), 32'd0);
      send(8'h01, 0, 0, 0, 0);
      result("ovf", 1, 0, 0, 1, 4);
      tick();
      send(8'h01, 0, 0, 0, 0);
      send(8'h01, 0, 0, 0, 0);
      send(8'h01, 0, 0, 0, 0);
      send(8'h01, 1, 0, 0, 0);
      result("full_last", 1, 0, 0, 0, 4);
      tick();
      // reset mid-frame discards the partial frame
      send(8'h01, 0, 0, 0, 0);
      send(8'h01, 0, 0, 0, 0);
      rst_n = 1'b0;
      #2;
      result("rst_mid", 0, 0, 0, 0, 0);
      check("rst_mid.s_ready", 32'(s_ready), 32'd1);
      rst_n = 1'b1;
      tick();
      send(8'h80, 1, 0, 0, 0);
      result("after_rst", 1, 1, 0, 0, 1);
      // reset also discards a pending result
      m_ready = 1'b0;
      tick();
      check("pend.valid", 32'(m_valid), 32'd1);
      rst_n = 1'b0;
      #2;
      result("rst_pend", 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      m_ready = 1'b1;
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/parity_stream.md
# parity_stream

Streaming, parametrised parity generator/checker: the sequential successor of the fixed 3-input XOR cell. Accumulates even/odd parity over a frame of WIDTH-bit words delivered on a valid/ready stream. Emits one registered result per frame: parity bit, word count, check error, overflow. Sits between a word source (UART/bus framer) and a consumer that appends or verifies parity.

## Interface
- WIDTH, 8, data word width (≥1)
- MAX_WORDS, 16, maximum words per frame (≥1)
- COUNT_W, $clog2(MAX_WORDS+1), width of word counter/output count
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_odd  in  1  0 = even parity, 1 = odd parity; sampled on first word of a frame
- i_check  in  1  0 = generate, 1 = check against s_par; sampled on first word of a frame
- s_valid  in  1  input word valid
- s_ready  out  1  block accepts word this cycle
- s_data  in  WIDTH  input word
- s_last  in  1  word is last of frame
- s_par  in  1  expected parity bit; meaningful on last word in check mode
- m_valid  out  1  result valid
- m_ready  in  1  consumer accepts result
- m_parity  out  1  computed parity bit
- m_error  out  1  check mode: m_parity ≠ s_par of last word; 0 in generate mode
- m_overflow  out  1  frame closed by MAX_WORDS, not by s_last
- m_count  out  COUNT_W  words in the frame (1..MAX_WORDS)

## Operation
- Word accepted when s_valid && s_ready.
- States: IDLE (no frame open), ACCUM (frame open), HOLD (result pending).
- IDLE: accept → acc = ^s_data, cnt = 1, latch i_odd/i_check; go ACCUM unless frame closes.
- ACCUM: accept → acc ^= ^s_data, cnt += 1.
- Frame closes on accepted word with s_last=1, or when that word makes cnt == MAX_WORDS (then m_overflow=1 unless s_last also 1).
- On close: m_parity = acc_final ^ odd_latched; m_error = check_latched && (m_parity != s_par); m_count = cnt; m_valid=1; go HOLD.
- HOLD: s_ready = m_ready. m_ready=1 with no accept → IDLE, m_valid=0. m_ready=1 with accept → new frame starts that cycle (as IDLE); if that word also closes, new result loaded, m_valid stays 1, stay HOLD.
- s_ready = 1 in IDLE and ACCUM.
- i_odd/i_check changes mid-frame ignored.
- MAX_WORDS=1: every word closes a frame; overflow only if s_last=0.

## Timing
- Reset (async assert, sync release): state IDLE, acc=0, cnt=0; m_valid=0, m_parity=0, m_error=0, m_overflow=0, m_count=0; s_ready=1.
- Reset mid-frame discards partial frame and any pending result immediately.
- Latency: result valid on the cycle after the closing word is accepted.
- m_* outputs stable while m_valid && !m_ready.
- s_ready combinational from state and m_ready only; no path from s_valid.
- Throughput: one word per cycle; back-to-back single-word frames sustain one result per cycle when m_ready=1.

## Structure
- Package parity_pkg: state enum (ST_IDLE, ST_ACCUM, ST_HOLD), parity-mode constants PAR_EVEN=1'b0, PAR_ODD=1'b1.
- Sub-module parity_tree: combinational WIDTH-input XOR reduction (generalised xor_3), one instance on s_data.
- Top: FSM, accumulator, counter, output register.

## Test plan
- WIDTH=8, MAX_WORDS=4, even, generate: 8'hA5 last → next cycle m_valid=1, m_parity=0, m_count=1, m_error=0, m_overflow=0.
- Odd, generate: 8'h01, 8'h03, 8'h07(last) → m_parity=1, m_count=3; i_odd toggled after first word has no effect.
- Even, check: 8'hFF last with s_par=1 → m_parity=0, m_error=1; repeat with s_par=0 → m_error=0.
- Backpressure: hold m_ready=0 3 cycles → s_ready=0, outputs unchanged; then m_ready=1 with 8'h80 last offered same cycle → accepted, next cycle m_valid=1, m_parity=1, m_count=1.
- Overflow: four 8'h01 words, s_last=0 → after 4th, m_valid=1, m_overflow=1, m_count=4, m_parity=0; fourth with s_last=1 → m_overflow=0.
- Reset mid-frame: 2 words accepted, pulse rst_n=0 → all m_* 0 immediately, s_ready=1; then 8'h80 last even → m_parity=1, m_count=1.
